// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator. It has parametrised porches, sync polarity and colour width.
// All outputs are registered one cycle after the counter state they describe. Free-running with no backpressure.
module vga_pattern_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int COLOR_W    = 3,
   parameter int CNT_W      = 11,
   parameter int CHECK_LOG2 = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   output logic [COLOR_W-1:0] pixel,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               active_out,
   output logic               frame_start,
   output logic [CNT_W-1:0]   x_out,
   output logic [CNT_W-1:0]   y_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
   localparam logic [COLOR_W-1:0] ONES   = '1;

   logic [CNT_W-1:0]   h, v, bar_col;
   logic [2:0]         bar_seg;
   logic [1:0]         mode_q;
   logic [COLOR_W-1:0] bar_pix, pix_nxt;
   logic               h_wrap, v_wrap, act_nxt, grid_hit;

   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h       <= '0;
         v       <= '0;
         bar_col <= '0;
         bar_seg <= '0;
         mode_q  <= '0;
      end else begin
         if (h_wrap) begin
            h       <= '0;
            bar_col <= '0;
            bar_seg <= '0;
            v       <= v_wrap ? '0 : v + CNT_W'(1);
         end else begin
            h <= h + CNT_W'(1);
            // bar index tracks h without a divider; it wraps harmlessly in blanking
            if (bar_col == BAR_LAST) begin
               bar_col <= '0;
               bar_seg <= bar_seg + 3'd1;
            end else begin
               bar_col <= bar_col + CNT_W'(1);
            end
         end
         // sampled on the frame-wrap edge so pixel (0,0) already uses the new mode
         if (h_wrap && v_wrap)
            mode_q <= mode;
      end
   end

   generate
      if (COLOR_W > 3) begin : g_bar_ext
         assign bar_pix = {{(COLOR_W-3){1'b0}}, bar_seg};
      end else if (COLOR_W == 3) begin : g_bar_eq
         assign bar_pix = bar_seg;
      end else begin : g_bar_trunc
         assign bar_pix = bar_seg[COLOR_W-1:0];
      end
   endgenerate

   always_comb begin
      act_nxt  = (h < H_ACT) && (v < V_ACT);
      grid_hit = (h[CHECK_LOG2-1:0] == '0) || (v[CHECK_LOG2-1:0] == '0) ||
                 (h == X_MAX) || (v == Y_MAX);
      pix_nxt  = '0;
      if (act_nxt) begin
         case (mode_q)
            2'd0:    pix_nxt = ONES;
            2'd1:    pix_nxt = bar_pix;
            2'd2:    pix_nxt = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? ONES : '0;
            default: pix_nxt = grid_hit ? ONES : '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel       <= '0;
         hsync_out   <= ~HSYNC_POL;
         vsync_out   <= ~VSYNC_POL;
         active_out  <= 1'b0;
         frame_start <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
      end else begin
         pixel       <= pix_nxt;
         hsync_out   <= ((h >= HS_BEG) && (h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
         vsync_out   <= ((v >= VS_BEG) && (v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
         active_out  <= act_nxt;
         frame_start <= (h == '0) && (v == '0);
         x_out       <= h;
         y_out       <= v;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a 24x12 small timing. Expected values are queued per
// post-reset pixel index; a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_pattern_gen;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;   // 24
   localparam int VT = VA + VF + VS + VB;   // 12
   localparam int FR = HT * VT;             // 288

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [1:0]  mode_p = 2'd3;
   logic [2:0]  pixel, pixel_p;
   logic        hs, vs, act, fs, hs_p, vs_p, act_p, fs_p;
   logic [10:0] x, y, x_p, y_p;

   vga_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(3), .CNT_W(11), .CHECK_LOG2(1)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .pixel(pixel), .hsync_out(hs), .vsync_out(vs),
      .active_out(act), .frame_start(fs), .x_out(x), .y_out(y)
   );

   vga_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COLOR_W(3), .CNT_W(11), .CHECK_LOG2(1)
   ) dut_p (
      .clk(clk), .rst(rst), .mode(mode_p), .pixel(pixel_p), .hsync_out(hs_p), .vsync_out(vs_p),
      .active_out(act_p), .frame_start(fs_p), .x_out(x_p), .y_out(y_p)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int id;
      int val;
   } exp_t;

   exp_t  q[$];
   string names[9] = '{"pixel", "hsync", "vsync", "active", "frame_start", "x", "y",
                       "pixel_p", "hsync_p"};
   int    n_cmp = 0;
   int    n_bad = 0;
   int    edges = 0;
   int    bar_line[24] = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,0,0,0,0,0,0,0,0};

   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else     edges <= edges + 1;
   end

   function automatic logic [31:0] get_act(int id);
      case (id)
         0:       return 32'(pixel);
         1:       return 32'(hs);
         2:       return 32'(vs);
         3:       return 32'(act);
         4:       return 32'(fs);
         5:       return 32'(x);
         6:       return 32'(y);
         7:       return 32'(pixel_p);
         default: return 32'(hs_p);
      endcase
   endfunction

   task automatic check(string nm, logic [31:0] a, logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, a, e);
      end
   endtask

   task automatic push(int p, int id, int val);
      exp_t e;
      e.p = p; e.id = id; e.val = val;
      q.push_back(e);
   endtask

   task automatic check_reset(string tag);
      check({tag, " pixel"},   32'(pixel),   32'd0);
      check({tag, " hsync"},   32'(hs),      32'd1);
      check({tag, " vsync"},   32'(vs),      32'd1);
      check({tag, " active"},  32'(act),     32'd0);
      check({tag, " fs"},      32'(fs),      32'd0);
      check({tag, " x"},       32'(x),       32'd0);
      check({tag, " y"},       32'(y),       32'd0);
      check({tag, " hsync_p"}, 32'(hs_p),    32'd0);
      check({tag, " pixel_p"}, 32'(pixel_p), 32'd0);
   endtask

   // monitor: output seen at the negedge after post-reset edge k describes pixel index p = k-1
   always @(negedge clk) begin : mon
      exp_t e;
      int   p;
      if (!rst && edges > 0) begin
         p = edges - 1;
         while (q.size() > 0 && q[0].p <= p) begin
            e = q.pop_front();
            if (e.p != p) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sched %s: slot %0d passed, now at %0d", names[e.id], e.p, p);
            end else begin
               check($sformatf("%s p=%0d", names[e.id], p), get_act(e.id), 32'(e.val));
            end
         end
      end
   end

   task automatic drain(string tag);
      for (int i = 0; i < 3000 && q.size() > 0; i++) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s drain: %0d expectations left, expected 0", tag, q.size());
         q.delete();
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      #1 check_reset("init");
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // frames 0-1 solid, frame 2 checker (lines 0-3), frame 3 line 0 colour bars
      for (int p = 0; p < 3 * FR + HT; p++) begin
         int h, v;
         bit a;
         h = p % HT;
         v = (p / HT) % VT;
         a = (h < HA) && (v < VA);
         push(p, 1, (h >= 18 && h < 21) ? 0 : 1);
         push(p, 2, (v >= 9 && v < 11) ? 0 : 1);
         push(p, 3, a ? 1 : 0);
         push(p, 4, (h == 0 && v == 0) ? 1 : 0);
         push(p, 5, h);
         push(p, 6, v);
         if (p < 2 * FR)
            push(p, 0, a ? 7 : 0);
         else if (p < 2 * FR + 4 * HT)
            push(p, 0, (a && ((((h >> 1) ^ (v >> 1)) & 1) == 1)) ? 7 : 0);
         else if (p >= 3 * FR)
            push(p, 0, bar_line[h]);
         push(p, 8, (h >= 18 && h < 21) ? 1 : 0);
         if (p >= FR && p < FR + 2 * HT) begin
            if (v == 0)
               push(p, 7, a ? 7 : 0);
            else
               push(p, 7, (a && (h % 2 == 0 || h == HA - 1)) ? 7 : 0);
         end
      end

      repeat (360) @(posedge clk);
      #1 mode = 2'd2;
      repeat (400) @(posedge clk);
      #1 mode = 2'd1;
      drain("run_a");

      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset("async");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      push(0, 4, 1);
      push(0, 0, 7);
      push(0, 3, 1);
      push(0, 5, 0);
      push(0, 6, 0);
      push(0, 7, 7);
      push(1, 4, 0);
      push(1, 0, 7);
      push(1, 5, 1);
      drain("run_b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
